// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register offsets, status bit positions and TX FSM states
package mmio_uart_pkg;
   localparam logic [15:0] REG_DATA = 16'd0;
   localparam logic [15:0] REG_STAT = 16'd1;
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/mmio_uart_if.sv
// mmio_uart_if: CPU word bus between a master and the UART register slave
interface mmio_uart_if;
   logic [15:0] address;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        wren_n;
   logic        oen_n;
   modport master (output address, data_in, wren_n, oen_n, input data_out);
   modport slave (input address, data_in, wren_n, oen_n, output data_out);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO; a push on a full FIFO lands only alongside a pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic wr_en, rd_en;
   assign empty = wptr == rptr;
   assign full  = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wr_en ? wptr + 1'b1 : wptr;
         rptr <= rd_en ? rptr + 1'b1 : rptr;
      end
      if (wr_en) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 transmitter with a byte FIFO and status register
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   mmio_uart_if.slave bus,
   output logic       tx
);
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   state_t state, state_n;
   logic [15:0] cnt, cnt_n, status;
   logic [2:0] idx, idx_n;
   logic [7:0] sh, sh_n, head;
   logic tx_n, pop, full, empty, ovf, last, wr_data, wr_stat, rd_stat;
   logic unused_hi;
   assign unused_hi = ^bus.data_in[15:8];
   assign wr_data = !bus.wren_n && bus.address == BASE_ADDR + REG_DATA;
   assign wr_stat = !bus.wren_n && bus.address == BASE_ADDR + REG_STAT;
   assign rd_stat = !bus.oen_n && bus.address == BASE_ADDR + REG_STAT;
   assign last = cnt == '0;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk), .rst(rst), .push(wr_data), .pop(pop), .din(bus.data_in[7:0]),
      .dout(head), .full(full), .empty(empty)
   );
   always_comb begin
      status = '0;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_BUSY]  = state != IDLE;
      status[ST_OVF]   = ovf;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         tx <= 1'b1;
         ovf <= 1'b0;
         bus.data_out <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         sh <= sh_n;
         tx <= tx_n;
         ovf <= (wr_data && full && !pop) || (ovf && !(wr_stat && bus.data_in[ST_OVF]));
         bus.data_out <= rd_stat ? status : '0;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = last ? DIV_M1 : cnt - 16'd1;
      idx_n = idx;
      sh_n = sh;
      tx_n = tx;
      pop = 1'b0;
      case (state)
         IDLE: cnt_n = cnt;
         START: if (last) begin
            state_n = DATA;
            idx_n = '0;
            tx_n = sh[0];
         end
         DATA: if (last) begin
            if (idx == 3'd7) begin
               state_n = STOP;
               tx_n = 1'b1;
            end else begin
               idx_n = idx + 3'd1;
               sh_n = {1'b0, sh[7:1]};
               tx_n = sh[1];
            end
         end
         STOP: if (last) begin
            state_n = IDLE;
            cnt_n = '0;
         end
      endcase
      // a waiting byte starts its frame straight out of IDLE or the final stop cycle
      if ((state == IDLE || (state == STOP && last)) && !empty) begin
         pop = 1'b1;
         sh_n = head;
         state_n = START;
         cnt_n = DIV_M1;
         tx_n = 1'b0;
      end
   end
endmodule
